// File: rtl/bcd_key_pkg.sv
// Shared types and helpers for the two-digit BCD key counter.
// BCD_KEY_REPEAT_EN (see bcd_key_counter.sv) enables held-key auto-repeat.
package bcd_key_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_count_t;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_UP,
        ACT_DN,
        ACT_LOAD
    } action_e;

    function automatic bcd_t bcd_clamp(input bcd_t nibble);
        return (nibble > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : nibble;
    endfunction

endpackage

// File: rtl/bcd_key_counter_if.sv
// Pushbutton/switch inputs and BCD digit outputs of the key counter.
interface bcd_key_counter_if;
    import bcd_key_pkg::*;

    logic       KEY_UP_N;
    logic       KEY_DN_N;
    logic       KEY_LD_N;
    logic [7:0] SW;
    bcd_t       DIGIT1;
    bcd_t       DIGIT0;
    logic       WRAP;

    modport master (
        output KEY_UP_N, KEY_DN_N, KEY_LD_N, SW,
        input  DIGIT1, DIGIT0, WRAP
    );

    modport slave (
        input  KEY_UP_N, KEY_DN_N, KEY_LD_N, SW,
        output DIGIT1, DIGIT0, WRAP
    );

endinterface

// File: rtl/key_debounce.sv
// Raw active-low pushbutton -> 2-flop synchronizer, stable-level debounce,
// debounced pressed level and a one-cycle registered press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic KEY_N,
    output logic PRESSED,
    output logic PRESS
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= KEY_N;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // Level accepted; only the falling (press) direction pulses.
                cnt_q   <= '0;
                level_q <= sync2_q;
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign PRESSED = ~level_q;
    assign PRESS   = press_q;

endmodule

// File: rtl/bcd_key_counter.sv
// Two-digit BCD up/down/load counter driven by debounced pushbuttons.
// Define BCD_KEY_REPEAT_EN to add held-key auto-repeat (REPEAT_CYCLES).
module bcd_key_counter
    import bcd_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_COUNT       = 99
`ifdef BCD_KEY_REPEAT_EN
    , parameter int REPEAT_CYCLES = 25000000
`endif
) (
    input logic              CLOCK_50,
    input logic              RESET,
    bcd_key_counter_if.slave bus
);

    localparam bcd_count_t MAX_BCD = '{tens: bcd_t'(MAX_COUNT / 10),
                                       ones: bcd_t'(MAX_COUNT % 10)};
    localparam logic [6:0] MAX_BIN = 7'(MAX_COUNT);

    logic up_press, dn_press, ld_press;
    logic up_held, dn_held, ld_held;
    logic step_up, step_dn;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY_N    (bus.KEY_UP_N),
        .PRESSED  (up_held),
        .PRESS    (up_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dn (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY_N    (bus.KEY_DN_N),
        .PRESSED  (dn_held),
        .PRESS    (dn_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_ld (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY_N    (bus.KEY_LD_N),
        .PRESSED  (ld_held),
        .PRESS    (ld_press)
    );

    // Held levels only matter to the repeat timer.
    logic unused_held;

`ifdef BCD_KEY_REPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             single_held;
    logic             rpt_tick;

    assign single_held = up_held ^ dn_held;
    assign rpt_tick    = single_held && (rpt_cnt_q == RPT_LAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            rpt_cnt_q <= '0;
        end else if (!single_held || up_press || dn_press || ld_press || rpt_tick) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
        end
    end

    assign step_up     = up_press | (rpt_tick & up_held);
    assign step_dn     = dn_press | (rpt_tick & dn_held);
    assign unused_held = ld_held;
`else
    assign step_up     = up_press;
    assign step_dn     = dn_press;
    assign unused_held = ^{up_held, dn_held, ld_held};
`endif

    bcd_count_t load_raw;
    bcd_count_t load_val;
    logic [6:0] load_bin;

    assign load_raw.tens = bcd_clamp(bus.SW[7:4]);
    assign load_raw.ones = bcd_clamp(bus.SW[3:0]);
    assign load_bin      = 7'(load_raw.tens) * 7'd10 + 7'(load_raw.ones);
    assign load_val      = (load_bin > MAX_BIN) ? MAX_BCD : load_raw;

    action_e    act;
    bcd_count_t count_q, count_d;
    logic       wrap_q, wrap_d;

    always_comb begin
        act = ACT_HOLD;
        if (ld_press) begin
            act = ACT_LOAD;
        end else if (step_up && !step_dn) begin
            act = ACT_UP;
        end else if (step_dn && !step_up) begin
            act = ACT_DN;
        end
    end

    // NOTE: defaults first so every path assigns every output; no latch inferred.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        case (act)
            ACT_UP: begin
                if (count_q == MAX_BCD) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else if (count_q.ones == BCD_MAX_DIGIT) begin
                    count_d.ones = '0;
                    count_d.tens = count_q.tens + 1'b1;
                end else begin
                    count_d.ones = count_q.ones + 1'b1;
                end
            end
            ACT_DN: begin
                if (count_q == '0) begin
                    count_d = MAX_BCD;
                    wrap_d  = 1'b1;
                end else if (count_q.ones == '0) begin
                    count_d.ones = BCD_MAX_DIGIT;
                    count_d.tens = count_q.tens - 1'b1;
                end else begin
                    count_d.ones = count_q.ones - 1'b1;
                end
            end
            ACT_LOAD: count_d = load_val;
            default:  ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.DIGIT1 = count_q.tens;
    assign bus.DIGIT0 = count_q.ones;
    assign bus.WRAP   = wrap_q;

endmodule
